// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state type and frame constants
package uart_pkg;

  // Frame phases shared by the transmitter and the receiver
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // 9600 baud at 50 MHz
  localparam int T_DEFAULT = 5208;

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period counter producing a one-cycle bit_end pulse
module uart_baud_cnt #(
  parameter int T = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_end
);

  localparam int CW = (T > 1) ? $clog2(T) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_end = en && (cnt_q == CW'(T - 1));

  // Count 0..T-1 while enabled, wrap at each bit boundary, park at 0 when idle
  always_comb begin
    cnt_d = cnt_q;
    if (!en || bit_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter, start/8N/stop framing; UART_TX_PARITY_EN adds even parity
module uart_tx
  import uart_pkg::*;
#(
  parameter int T      = T_DEFAULT,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_uart,
  output logic              tx_busy
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  uart_state_e       state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              tx_q, tx_d;
  logic              bit_end;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  uart_baud_cnt #(
    .T(T)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .en     (state_q != IDLE),
    .bit_end(bit_end)
  );

  // The line level is computed one step ahead so tx_uart comes straight from a flop
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d = STOP_BIT;
        if (tx_valid) begin
          shift_d = tx_data;
          bit_d   = '0;
          tx_d    = START_BIT;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^tx_data;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == BW'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = PARITY;
`else
            tx_d    = STOP_BIT;
            state_d = STOP;
`endif
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + BW'(1);
            tx_d    = shift_d[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          tx_d    = STOP_BIT;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          tx_d    = STOP_BIT;
          state_d = IDLE;
        end
      end
      default: begin
        tx_d    = STOP_BIT;
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and line registers; reset aborts any frame with the line high
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= STOP_BIT;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx_uart  = tx_q;
  assign tx_ready = (state_q == IDLE);
  assign tx_busy  = ~tx_ready;

endmodule
